// File: rtl/ram_test_sequencer.sv
// rtl/ram_test_sequencer.sv - bus master that fills an address range with a pattern and verifies it
// Each access is SETUP, two-cycle STRB, HOLD; every output is a flop loaded from next-state logic.
module ram_test_sequencer (
  input  logic       bclk,
  input  logic       bnRST,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] first_addr,
  input  logic [7:0] last_addr,
  input  logic [7:0] seed,
  output logic [7:0] ABus,
  output logic [7:0] out244,
  output logic       bnRD,
  output logic       bnWR,
  input  logic [7:0] DBus,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] err_addr,
  output logic [7:0] rd_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_SETUP = 3'd1;
  localparam logic [2:0] S_W_STRB  = 3'd2;
  localparam logic [2:0] S_W_HOLD  = 3'd3;
  localparam logic [2:0] S_R_SETUP = 3'd4;
  localparam logic [2:0] S_R_STRB  = 3'd5;
  localparam logic [2:0] S_R_HOLD  = 3'd6;
  localparam logic [2:0] S_FINISH  = 3'd7;

  logic [2:0] state_q, state_d;
  logic       strb_cnt_q, strb_cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] first_q, first_d;
  logic [7:0] last_q, last_d;
  logic [7:0] seed_q, seed_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] out244_q, out244_d;
  logic       bnrd_q, bnrd_d;
  logic       bnwr_q, bnwr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] err_addr_q, err_addr_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic [7:0] addr_inc;
  logic       range_end;
  logic       fill_only;

  assign addr_inc  = addr_q + 8'd1;
  assign range_end = (addr_q == last_q);
  assign fill_only = (mode_q == 2'd0);

  always_comb begin
    state_d    = state_q;
    strb_cnt_d = strb_cnt_q;
    mode_d     = mode_q;
    first_d    = first_q;
    last_d     = last_q;
    seed_d     = seed_q;
    addr_d     = addr_q;
    out244_d   = out244_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          first_d    = first_addr;
          last_d     = last_addr;
          seed_d     = seed;
          addr_d     = first_addr;
          strb_cnt_d = 1'b0;
          err_cnt_d  = 8'h00;
          err_addr_d = 8'h00;
          pass_d     = 1'b0;
          rd_data_d  = 8'h00;
          if (mode == 2'd1) begin
            state_d = S_R_SETUP;
          end else begin
            state_d  = S_W_SETUP;
            out244_d = first_addr ^ seed;
          end
        end
      end
      S_W_SETUP: begin
        state_d    = S_W_STRB;
        strb_cnt_d = 1'b0;
      end
      S_W_STRB: begin
        if (!strb_cnt_q) begin
          strb_cnt_d = 1'b1;
        end else begin
          strb_cnt_d = 1'b0;
          state_d    = S_W_HOLD;
        end
      end
      S_W_HOLD: begin
        if (range_end) begin
          if (fill_only) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_R_SETUP;
            addr_d  = first_q;
          end
        end else begin
          state_d  = S_W_SETUP;
          addr_d   = addr_inc;
          out244_d = addr_inc ^ seed_q;
        end
      end
      S_R_SETUP: begin
        state_d    = S_R_STRB;
        strb_cnt_d = 1'b0;
      end
      S_R_STRB: begin
        if (!strb_cnt_q) begin
          strb_cnt_d = 1'b1;
        end else begin
          // RAM q has been stable for a full cycle here
          strb_cnt_d = 1'b0;
          state_d    = S_R_HOLD;
          rd_data_d  = DBus;
          if (DBus != (addr_q ^ seed_q)) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (err_cnt_q == 8'h00) err_addr_d = addr_q;
          end
        end
      end
      S_R_HOLD: begin
        if (range_end) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_R_SETUP;
          addr_d  = addr_inc;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes and status are decoded from the next state so they leave a flop
    bnwr_d = (state_d != S_W_STRB);
    bnrd_d = (state_d != S_R_STRB);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
    if (state_d == S_FINISH) pass_d = fill_only || (err_cnt_d == 8'h00);
  end

  always_ff @(posedge bclk or negedge bnRST) begin
    if (!bnRST) begin
      state_q    <= S_IDLE;
      strb_cnt_q <= 1'b0;
      mode_q     <= 2'd0;
      first_q    <= 8'h00;
      last_q     <= 8'h00;
      seed_q     <= 8'h00;
      addr_q     <= 8'h00;
      out244_q   <= 8'h00;
      bnrd_q     <= 1'b1;
      bnwr_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 8'h00;
      err_addr_q <= 8'h00;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      strb_cnt_q <= strb_cnt_d;
      mode_q     <= mode_d;
      first_q    <= first_d;
      last_q     <= last_d;
      seed_q     <= seed_d;
      addr_q     <= addr_d;
      out244_q   <= out244_d;
      bnrd_q     <= bnrd_d;
      bnwr_q     <= bnwr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ABus     = addr_q;
  assign out244   = out244_q;
  assign bnRD     = bnrd_q;
  assign bnWR     = bnwr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
  assign rd_data  = rd_data_q;

endmodule
